// File: rtl/buzzer_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_pkg
// Shared definitions for the buzzer tone/cadence generator.
//   buzzer_state_t : cadence FSM states (IDLE, TONE, GAP, PAUSE)
//   DEF_*          : default timing parameters for a 50 MHz system clock
//   max3           : helper used to size the shared segment counter
// -----------------------------------------------------------------------------
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } buzzer_state_t;

    localparam int DEF_HALF_PERIOD = 12500;  // 2 kHz tone at 50 MHz
    localparam int DEF_TICK_DIV    = 50000;  // 1 ms tick at 50 MHz
    localparam int DEF_ON_TICKS    = 250;
    localparam int DEF_OFF_TICKS   = 250;
    localparam int DEF_BURSTS      = 4;
    localparam int DEF_PAUSE_TICKS = 1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/buzzer_prescaler.sv
// -----------------------------------------------------------------------------
// buzzer_prescaler
// Divides the system clock down to the cadence timing tick.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   clear  : synchronous clear, restarts the division from zero
//   tick   : one-cycle pulse on the last clock of every TICK_DIV-clock interval
// -----------------------------------------------------------------------------
module buzzer_prescaler
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("buzzer_prescaler: TICK_DIV must be >= 1");
    end

    localparam int              CW   = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // tick deliberately ignores clear: the FSM derives clear from tick, so
    // gating here would form a combinational loop.
    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// buzzer_tone_gen
// Turns the buzzer PIO bit into an alarm cadence: BURSTS beeps of a square-wave
// tone separated by gaps, then a pause, repeating while enable is high.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   enable     : PIO out_port bit, level-sensitive
//   buzzer_out : registered square wave to the piezo pin
//   busy       : registered, high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int ON_TICKS    = DEF_ON_TICKS,
    parameter int OFF_TICKS   = DEF_OFF_TICKS,
    parameter int BURSTS      = DEF_BURSTS,
    parameter int PAUSE_TICKS = DEF_PAUSE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic buzzer_out,
    output logic busy
);

    if (HALF_PERIOD < 1 || TICK_DIV < 1 || ON_TICKS < 1 ||
        OFF_TICKS < 1 || BURSTS < 1 || PAUSE_TICKS < 1) begin : g_bad_param
        $error("buzzer_tone_gen: all timing parameters must be >= 1");
    end

    // One segment counter is shared by TONE, GAP and PAUSE, so it is sized
    // for the longest of the three.
    localparam int SW = $clog2(max3(ON_TICKS, OFF_TICKS, PAUSE_TICKS) + 1);
    localparam int HW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(BURSTS + 1);

    localparam logic [SW-1:0] ON_LAST    = SW'(ON_TICKS - 1);
    localparam logic [SW-1:0] OFF_LAST   = SW'(OFF_TICKS - 1);
    localparam logic [SW-1:0] PAUSE_LAST = SW'(PAUSE_TICKS - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(BURSTS);

    buzzer_state_t state;
    logic [SW-1:0] seg_cnt;
    logic [HW-1:0] half_cnt;
    logic [BW-1:0] burst_cnt;
    logic          tick;
    logic          seg_done;
    logic          presc_clear;

    // Last clock of the current segment: final tick of its tick budget.
    always_comb begin
        seg_done = 1'b0;
        unique case (state)
            TONE:    seg_done = tick && (seg_cnt == ON_LAST);
            GAP:     seg_done = tick && (seg_cnt == OFF_LAST);
            PAUSE:   seg_done = tick && (seg_cnt == PAUSE_LAST);
            default: seg_done = 1'b0;
        endcase
    end

    // Restart the prescaler whenever the next edge enters a new state, so
    // every segment is an exact multiple of TICK_DIV clocks.
    assign presc_clear = !enable || (state == IDLE) || seg_done;

    buzzer_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Cadence FSM. buzzer_out doubles as the tone phase register: it is set
    // on every TONE entry and toggled by the half-period counter. Segment
    // transitions are handled before the toggle, so they win on a tie.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state      <= IDLE;
            buzzer_out <= 1'b0;
            busy       <= 1'b0;
            seg_cnt    <= '0;
            half_cnt   <= '0;
            burst_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state      <= TONE;
                    busy       <= 1'b1;
                    buzzer_out <= 1'b1;
                    burst_cnt  <= BW'(1);
                    seg_cnt    <= '0;
                    half_cnt   <= '0;
                end
                TONE: begin
                    if (seg_done) begin
                        state      <= (burst_cnt < BURST_MAX) ? GAP : PAUSE;
                        buzzer_out <= 1'b0;
                        seg_cnt    <= '0;
                        half_cnt   <= '0;
                    end else begin
                        if (tick) begin
                            seg_cnt <= seg_cnt + SW'(1);
                        end
                        if (half_cnt == HALF_LAST) begin
                            half_cnt   <= '0;
                            buzzer_out <= !buzzer_out;
                        end else begin
                            half_cnt <= half_cnt + HW'(1);
                        end
                    end
                end
                GAP: begin
                    if (seg_done) begin
                        state      <= TONE;
                        buzzer_out <= 1'b1;
                        burst_cnt  <= burst_cnt + BW'(1);
                        seg_cnt    <= '0;
                        half_cnt   <= '0;
                    end else if (tick) begin
                        seg_cnt <= seg_cnt + SW'(1);
                    end
                end
                PAUSE: begin
                    if (seg_done) begin
                        state      <= TONE;
                        buzzer_out <= 1'b1;
                        burst_cnt  <= BW'(1);
                        seg_cnt    <= '0;
                        half_cnt   <= '0;
                    end else if (tick) begin
                        seg_cnt <= seg_cnt + SW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    buzzer_out <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_buzzer_tone_gen
// Directed bench for buzzer_tone_gen. A small-timing instance carries the main
// cadence scenarios, a BURSTS=1 instance covers the no-gap case, and a
// default-parameter instance confirms the real half-period length.
// -----------------------------------------------------------------------------
module tb_buzzer_tone_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic enable, enable_b1, enable_def;
    logic buz, busy_o, buz_b1, busy_b1, buz_def, busy_def;

    buzzer_tone_gen #(
        .HALF_PERIOD (2), .TICK_DIV (4), .ON_TICKS (2),
        .OFF_TICKS (1), .BURSTS (2), .PAUSE_TICKS (3)
    ) dut (
        .clk (clk), .reset (reset), .enable (enable),
        .buzzer_out (buz), .busy (busy_o)
    );

    buzzer_tone_gen #(
        .HALF_PERIOD (2), .TICK_DIV (4), .ON_TICKS (2),
        .OFF_TICKS (1), .BURSTS (1), .PAUSE_TICKS (3)
    ) dut_b1 (
        .clk (clk), .reset (reset), .enable (enable_b1),
        .buzzer_out (buz_b1), .busy (busy_b1)
    );

    buzzer_tone_gen dut_def (
        .clk (clk), .reset (reset), .enable (enable_def),
        .buzzer_out (buz_def), .busy (busy_def)
    );

    typedef struct {
        int   sel;
        logic buz;
        logic busy;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string tag    = "none";

    // Expected small-config waveform at position p of the 32-clock pattern:
    // TONE 0..7, GAP 8..11, TONE 12..19, PAUSE 20..31.
    function automatic logic pat_small(input int p);
        int q;
        q = p % 32;
        if (q < 8)       return ((q % 4) < 2);
        else if (q < 12) return 1'b0;
        else if (q < 20) return (((q - 12) % 4) < 2);
        else             return 1'b0;
    endfunction

    // BURSTS=1 waveform: TONE 0..7, PAUSE 8..19.
    function automatic logic pat_b1(input int p);
        int q;
        q = p % 20;
        if (q < 8) return ((q % 4) < 2);
        else       return 1'b0;
    endfunction

    task automatic checkOutput();
        exp_t e;
        logic ob;
        logic oy;
        e  = exp_q.pop_front();
        ob = (e.sel == 0) ? buz    : buz_b1;
        oy = (e.sel == 0) ? busy_o : busy_b1;
        checks++;
        assert (ob === e.buz) else begin
            errors++;
            $error("[TB] FAIL %s buzzer_out: observed %b expected %b", tag, ob, e.buz);
        end
        checks++;
        assert (oy === e.busy) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, oy, e.busy);
        end
    endtask

    // Drive one cycle of stimulus, record what the DUT must show after the
    // next edge, then sample 1 time unit after that edge.
    task automatic applyStimulus(input int sel, input logic rst, input logic en,
                                 input logic exp_buz, input logic exp_busy);
        exp_t e;
        reset = rst;
        if (sel == 0) enable = en;
        else          enable_b1 = en;
        e.sel  = sel;
        e.buz  = exp_buz;
        e.busy = exp_busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int hi;
        int lo;

        reset      = 1'b1;
        enable     = 1'b1;
        enable_b1  = 1'b0;
        enable_def = 1'b0;

        tag = "reset";
        repeat (3) applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);

        tag = "full_pattern";
        for (int i = 0; i < 64; i++) applyStimulus(0, 1'b0, 1'b1, pat_small(i), 1'b1);

        tag = "to_second_tone";
        for (int i = 0; i < 15; i++) applyStimulus(0, 1'b0, 1'b1, pat_small(i), 1'b1);

        tag = "mid_tone_disable";
        repeat (5) applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);

        tag = "mid_tone_reenable";
        for (int i = 0; i < 26; i++) applyStimulus(0, 1'b0, 1'b1, pat_small(i), 1'b1);

        tag = "pause_disable";
        repeat (2) applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);

        tag = "pause_reenable";
        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b0, 1'b1, pat_small(i), 1'b1);

        tag = "mid_reset";
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);

        tag = "after_mid_reset";
        for (int i = 0; i < 8; i++) applyStimulus(0, 1'b0, 1'b1, pat_small(i), 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);

        tag = "bursts1";
        for (int i = 0; i < 40; i++) applyStimulus(1, 1'b0, 1'b1, pat_b1(i), 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Default configuration: measure the first high and low half-cycles.
        tag = "default_half";
        enable_def = 1'b1;
        @(posedge clk);
        #1;
        hi = 0;
        while (buz_def === 1'b1 && hi < 20000) begin
            hi++;
            @(posedge clk);
            #1;
        end
        lo = 0;
        while (buz_def === 1'b0 && lo < 20000) begin
            lo++;
            @(posedge clk);
            #1;
        end
        checks++;
        assert (hi == 12500) else begin
            errors++;
            $error("[TB] FAIL %s high_len: observed %0d expected %0d", tag, hi, 12500);
        end
        checks++;
        assert (lo == 12500) else begin
            errors++;
            $error("[TB] FAIL %s low_len: observed %0d expected %0d", tag, lo, 12500);
        end
        checks++;
        assert (busy_def === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy_def, 1'b1);
        end
        enable_def = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        assert (buz_def === 1'b0 && busy_def === 1'b0) else begin
            errors++;
            $error("[TB] FAIL %s disable: observed %b%b expected 00", tag, buz_def, busy_def);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
